// File: rtl/snes_pkg.sv
// Shared types and constants for the SNES pad reader.
// Holds the frame state encoding, the button bit positions and the timing
// derivations. The SNES_DEBOUNCE_EN build option is handled in snes_pad_reader.
package snes_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        CLK_LO,
        CLK_HI,
        DONE
    } snes_state_e;

    localparam int BTN_B      = 0;
    localparam int BTN_Y      = 1;
    localparam int BTN_SELECT = 2;
    localparam int BTN_START  = 3;
    localparam int BTN_UP     = 4;
    localparam int BTN_DOWN   = 5;
    localparam int BTN_LEFT   = 6;
    localparam int BTN_RIGHT  = 7;
    localparam int BTN_A      = 8;
    localparam int BTN_X      = 9;
    localparam int BTN_L      = 10;
    localparam int BTN_R      = 11;

    // System-clock cycles in one half period of snes_clk.
    function automatic int half_cycles(input int clk_hz, input int half_us);
        return clk_hz / 1_000_000 * half_us;
    endfunction

    // System-clock cycles between consecutive frame starts.
    function automatic int poll_period(input int clk_hz, input int poll_hz);
        return clk_hz / poll_hz;
    endfunction

endpackage

// File: rtl/snes_pad_reader_if.sv
// Pad-side serial lines plus the decoded button outputs of the reader.
// master: the reader; slave: the pad and the game logic consuming buttons.
interface snes_pad_reader_if;
    logic        snes_data;
    logic        snes_latch;
    logic        snes_clk;
    logic [11:0] buttons;
    logic        up_out;
    logic        down_out;
    logic        left_out;
    logic        right_out;
    logic        frame_valid;
    logic        frame_err;

    modport master (
        input  snes_data,
        output snes_latch, snes_clk, buttons,
        output up_out, down_out, left_out, right_out,
        output frame_valid, frame_err
    );

    modport slave (
        output snes_data,
        input  snes_latch, snes_clk, buttons,
        input  up_out, down_out, left_out, right_out,
        input  frame_valid, frame_err
    );
endinterface

// File: rtl/snes_half_tick.sv
// Phase timer for the pad protocol: a down-counter loaded with the phase
// length; expire_o is high on the last cycle of the phase.
module snes_half_tick #(
    parameter int W = 9
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load_i,
    input  logic [W-1:0] len_i,
    output logic         expire_o
);
    logic [W-1:0] cnt_q, cnt_d;

    // Reload on phase entry, otherwise count down and park at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = len_i - W'(1);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - W'(1);
        end
    end

    // Counter register.
    always_ff @(posedge clk) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign expire_o = (cnt_q == '0);
endmodule

// File: rtl/snes_pad_reader.sv
// SNES gamepad poller: latches the pad, shifts 16 bits out of it and presents
// the 12 real buttons as active-high levels. Frames with any of the four
// always-released bits reading pressed are flagged and discarded.
// Build option SNES_DEBOUNCE_EN: buttons only change when two consecutive
// error-free frames agree.
//
// state  | meaning
// IDLE   | waiting for the poll counter to reach 0
// LATCH  | snes_latch high for 2*HALF cycles
// CLK_LO | snes_clk low for HALF cycles, sample on last cycle
// CLK_HI | snes_clk high for HALF cycles, advance bit index
// DONE   | one cycle, evaluate the frame and update outputs
module snes_pad_reader
    import snes_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 25_000_000,
    parameter int POLL_HZ     = 60,
    parameter int HALF_BIT_US = 6
) (
    input  logic               clk,
    input  logic               reset,
    snes_pad_reader_if.master  pad
);
    localparam int HALF   = half_cycles(CLK_FREQ_HZ, HALF_BIT_US);
    localparam int PERIOD = poll_period(CLK_FREQ_HZ, POLL_HZ);
    localparam int TW     = $clog2(2 * HALF + 1);
    localparam int PW     = $clog2(PERIOD);

    localparam logic [TW-1:0] LEN_HALF  = TW'(HALF);
    localparam logic [TW-1:0] LEN_LATCH = TW'(2 * HALF);

    // A frame must finish before the next poll starts.
    if (PERIOD <= 34 * HALF) begin : g_bad_timing
        $error("snes_pad_reader: poll period too short for one frame");
    end

    snes_state_e state_q, state_d;
    logic [PW-1:0] poll_q, poll_d;
    logic [3:0]    bit_q, bit_d;
    logic [15:0]   shreg_q, shreg_d;
    logic [11:0]   buttons_q, buttons_d;
    logic          err_q, err_d;
    logic          fv_q, fv_d;
    logic          latch_q, latch_d;
    logic          sclk_q, sclk_d;
    logic          data_meta_q, data_sync_q;
    logic          tick_load;
    logic [TW-1:0] tick_len;
    logic          tick_expire;
`ifdef SNES_DEBOUNCE_EN
    logic [11:0]   stable_q, stable_d;
`endif

    snes_half_tick #(.W(TW)) u_half_tick (
        .clk      (clk),
        .reset    (reset),
        .load_i   (tick_load),
        .len_i    (tick_len),
        .expire_o (tick_expire)
    );

    // Poll counter wraps at PERIOD; the value 0 requests a frame.
    always_comb begin
        poll_d = (poll_q == PW'(PERIOD - 1)) ? '0 : poll_q + PW'(1);
    end

    // Frame sequencing, sampling and output update.
    always_comb begin
        state_d   = state_q;
        bit_d     = bit_q;
        shreg_d   = shreg_q;
        buttons_d = buttons_q;
        err_d     = err_q;
        fv_d      = 1'b0;
        tick_load = 1'b0;
        tick_len  = LEN_HALF;
`ifdef SNES_DEBOUNCE_EN
        stable_d  = stable_q;
`endif
        case (state_q)
            IDLE: begin
                if (poll_q == '0) begin
                    state_d   = LATCH;
                    tick_load = 1'b1;
                    tick_len  = LEN_LATCH;
                end
            end
            LATCH: begin
                bit_d = 4'd0;
                if (tick_expire) begin
                    state_d   = CLK_LO;
                    tick_load = 1'b1;
                end
            end
            CLK_LO: begin
                if (tick_expire) begin
                    shreg_d[bit_q] = ~data_sync_q;
                    state_d        = CLK_HI;
                    tick_load      = 1'b1;
                end
            end
            CLK_HI: begin
                if (tick_expire) begin
                    if (bit_q != 4'd15) begin
                        bit_d     = bit_q + 4'd1;
                        state_d   = CLK_LO;
                        tick_load = 1'b1;
                    end else begin
                        state_d = DONE;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
                if (shreg_q[15:12] != 4'b0000) begin
                    err_d = 1'b1;
                end else begin
                    err_d = 1'b0;
`ifdef SNES_DEBOUNCE_EN
                    stable_d = shreg_q[11:0];
                    if (shreg_q[11:0] == stable_q) begin
                        buttons_d = shreg_q[11:0];
                        fv_d      = 1'b1;
                    end
`else
                    buttons_d = shreg_q[11:0];
                    fv_d      = 1'b1;
`endif
                end
            end
            default: state_d = IDLE;
        endcase
        latch_d = (state_d == LATCH);
        sclk_d  = (state_d != CLK_LO);
    end

    // State and datapath registers; pad lines are registered to stay glitch-free.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            poll_q      <= '0;
            bit_q       <= 4'd0;
            shreg_q     <= 16'h0000;
            buttons_q   <= 12'h000;
            err_q       <= 1'b0;
            fv_q        <= 1'b0;
            latch_q     <= 1'b0;
            sclk_q      <= 1'b1;
            data_meta_q <= 1'b1;
            data_sync_q <= 1'b1;
`ifdef SNES_DEBOUNCE_EN
            stable_q    <= 12'h000;
`endif
        end else begin
            state_q     <= state_d;
            poll_q      <= poll_d;
            bit_q       <= bit_d;
            shreg_q     <= shreg_d;
            buttons_q   <= buttons_d;
            err_q       <= err_d;
            fv_q        <= fv_d;
            latch_q     <= latch_d;
            sclk_q      <= sclk_d;
            data_meta_q <= pad.snes_data;
            data_sync_q <= data_meta_q;
`ifdef SNES_DEBOUNCE_EN
            stable_q    <= stable_d;
`endif
        end
    end

    assign pad.snes_latch  = latch_q;
    assign pad.snes_clk    = sclk_q;
    assign pad.buttons     = buttons_q;
    assign pad.up_out      = buttons_q[BTN_UP];
    assign pad.down_out    = buttons_q[BTN_DOWN];
    assign pad.left_out    = buttons_q[BTN_LEFT];
    assign pad.right_out   = buttons_q[BTN_RIGHT];
    assign pad.frame_valid = fv_q;
    assign pad.frame_err   = err_q;
endmodule

// File: tb/tb_snes_pad_reader.sv
`timescale 1ns/1ps
module tb_snes_pad_reader;
    localparam int CLK_HZ = 25_000_000;
    localparam int POLL   = 4500;
    localparam int HBU    = 6;
    localparam int HALF   = 150;
    localparam int PERIOD = CLK_HZ / POLL;
    localparam int FRAME  = 34 * HALF;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #20 clk = ~clk;

    snes_pad_reader_if pad ();

    snes_pad_reader #(
        .CLK_FREQ_HZ (CLK_HZ),
        .POLL_HZ     (POLL),
        .HALF_BIT_US (HBU)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .pad   (pad)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int unsigned cyc = 0;
    int unsigned last_latch = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Pad: parallel load while latched, shift on snes_clk rise, output ~bit.
    logic [15:0] pad_bits = 16'h0000;
    logic [15:0] pad_sr   = 16'h0000;
    bit          unplugged = 1'b0;
    logic        pclk_prev = 1'b1;
    always @(negedge clk) begin
        if (pad.snes_latch) pad_sr = pad_bits;
        else if (pad.snes_clk && !pclk_prev) pad_sr = {1'b0, pad_sr[15:1]};
        pclk_prev = pad.snes_clk;
        pad.snes_data = unplugged ? 1'b1 : ~pad_sr[0];
    end

    // Reference: what the game logic should see after each frame.
    logic [11:0] m_buttons = 12'h000;
    logic        m_err     = 1'b0;
`ifdef SNES_DEBOUNCE_EN
    logic [11:0] m_stable  = 12'h000;
`endif

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_reset();
        m_buttons = 12'h000;
        m_err     = 1'b0;
`ifdef SNES_DEBOUNCE_EN
        m_stable  = 12'h000;
`endif
    endtask

    task automatic model_frame(input logic [15:0] p, output bit fv);
        fv = 1'b0;
        if (p[15:12] != 4'h0) begin
            m_err = 1'b1;
        end else begin
            m_err = 1'b0;
`ifdef SNES_DEBOUNCE_EN
            if (p[11:0] == m_stable) begin
                m_buttons = p[11:0];
                fv = 1'b1;
            end
            m_stable = p[11:0];
`else
            m_buttons = p[11:0];
            fv = 1'b1;
`endif
        end
    endtask

    task automatic wait_latch_rise(input bit check_spacing);
        bit ok = 1'b0;
        for (int i = 0; i < PERIOD + 20; i++) begin
            @(negedge clk);
            if (pad.snes_latch) begin
                ok = 1'b1;
                break;
            end
        end
        check_eq("latch_seen", 32'(ok), 32'd1);
        if (ok && check_spacing) check_eq("poll_spacing", cyc - last_latch, PERIOD);
        last_latch = cyc;
    endtask

    // Called on the first sample with snes_latch high.
    task automatic measure_frame(input bit full, input logic [15:0] pressed);
        int lat = 0, falls = 0, fv_n = 0, fv_at = -1;
        int lo[16];
        int hi[16];
        logic pc = 1'b1;
        bit exp_fv;
        for (int i = 0; i < 16; i++) begin
            lo[i] = 0;
            hi[i] = 0;
        end
        for (int t = 0; t <= FRAME + 10; t++) begin
            if (t > 0) @(negedge clk);
            if (pad.snes_latch) lat++;
            if (!pad.snes_clk) begin
                if (pc) falls++;
                if (falls >= 1 && falls <= 16) lo[falls-1]++;
            end else if (falls >= 1 && falls <= 15) begin
                hi[falls-1]++;
            end
            pc = pad.snes_clk;
            if (pad.frame_valid) begin
                fv_n++;
                if (fv_at < 0) fv_at = t;
            end
        end
        model_frame(pressed, exp_fv);
        check_eq("latch_len", lat, 2 * HALF);
        check_eq("clk_falls", falls, 16);
        if (full) begin
            for (int i = 0; i < 16; i++) check_eq("clk_lo_len", lo[i], HALF);
            for (int i = 0; i < 15; i++) check_eq("clk_hi_len", hi[i], HALF);
        end
        check_eq("fv_count", fv_n, 32'(exp_fv));
        if (exp_fv) check_eq("fv_time", 32'(fv_at >= FRAME - 1 && fv_at <= FRAME + 1), 32'd1);
        check_eq("buttons", pad.buttons, m_buttons);
        check_eq("frame_err", pad.frame_err, m_err);
        check_eq("up_out", pad.up_out, m_buttons[4]);
        check_eq("down_out", pad.down_out, m_buttons[5]);
        check_eq("left_out", pad.left_out, m_buttons[6]);
        check_eq("right_out", pad.right_out, m_buttons[7]);
    endtask

    task automatic run_frame(input logic [15:0] pressed, input bit uplug);
        pad_bits  = pressed;
        unplugged = uplug;
        wait_latch_rise(1'b1);
        measure_frame(1'b0, uplug ? 16'h0000 : pressed);
    endtask

    initial begin
        logic [15:0] last_p, p;

        reset = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("rst_latch", pad.snes_latch, 1'b0);
        check_eq("rst_clk", pad.snes_clk, 1'b1);
        check_eq("rst_buttons", pad.buttons, 12'h000);
        check_eq("rst_fv", pad.frame_valid, 1'b0);
        check_eq("rst_err", pad.frame_err, 1'b0);
        model_reset();

        // Up + A, with full protocol timing check on the first frame.
        pad_bits = 16'h0110;
        reset = 1'b0;
        @(negedge clk);
        check_eq("first_latch", pad.snes_latch, 1'b1);
        last_latch = cyc;
        measure_frame(1'b1, 16'h0110);

        run_frame(16'h0110, 1'b0);
        run_frame(16'h2003, 1'b0);
        run_frame(16'h0080, 1'b0);
        run_frame(16'h0080, 1'b0);

        // Reset in the middle of bit 7's low phase.
        pad_bits = 16'h00F0;
        wait_latch_rise(1'b1);
        repeat (14 * HALF + 2 * HALF + 50) @(negedge clk);
        check_eq("mid_clk_lo", pad.snes_clk, 1'b0);
        reset = 1'b1;
        @(negedge clk);
        check_eq("abort_latch", pad.snes_latch, 1'b0);
        check_eq("abort_clk", pad.snes_clk, 1'b1);
        check_eq("abort_buttons", pad.buttons, 12'h000);
        check_eq("abort_err", pad.frame_err, 1'b0);
        check_eq("abort_fv", pad.frame_valid, 1'b0);
        model_reset();
        unplugged = 1'b1;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check_eq("restart_latch", pad.snes_latch, 1'b1);
        last_latch = cyc;
        measure_frame(1'b0, 16'h0000);

        // Randomized frames, sometimes repeating, sometimes with error bits.
        last_p = 16'h0000;
        for (int k = 0; k < 4; k++) begin
            if ($urandom_range(1, 0) == 1) p = last_p;
            else p = 16'($urandom_range(12'hFFF, 0));
            if ($urandom_range(3, 0) == 0) p[15:12] = 4'($urandom_range(15, 1));
            if (p[15:12] == 4'h0) last_p = p;
            run_frame(p, 1'b0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
